// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the simple word-addressed memory bus used between
// requesters (CPU data port, memory test master) and the SDRAM/SRAM controller.
//   MEM_A_W / MEM_D_W / MEM_ID_W : default address, data and id widths
//   MEM_M_W                      : byte-enable width (one bit per data byte)
//   ID_NONE                      : id value meaning "no read data returned"
//   mem_cmd_t                    : one bus command as seen by masters/controllers
//   cmd_read_eff()               : effective read strobe (write wins a collision)
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int MEM_A_W  = 30;
    localparam int MEM_D_W  = 32;
    localparam int MEM_ID_W = 2;
    localparam int MEM_M_W  = MEM_D_W / 8;

    localparam logic [MEM_ID_W-1:0] ID_NONE = 2'd0;

    typedef struct packed {
        logic [MEM_ID_W-1:0] id;
        logic [MEM_A_W-1:0]  address;
        logic                read;
        logic                write;
        logic [MEM_D_W-1:0]  writedata;
        logic [MEM_M_W-1:0]  writedatamask;
    } mem_cmd_t;

    // A master raising read and write together is illegal; the write is kept
    // and the read is dropped so the downstream never sees both strobes.
    function automatic logic cmd_read_eff(input logic read, input logic write);
        return read & ~write;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin pick.
//   req   [1:0] in  : request per master
//   last        in  : index of the master granted most recently
//   grant [1:0] out : one-hot grant (all zero when nobody requests)
// A lone requester always wins; on a tie the master that did not win last
// time is chosen.
// -----------------------------------------------------------------------------
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Round-robin pick from the request pair and the previous winner
    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter2.sv
// -----------------------------------------------------------------------------
// mem_arbiter2
// Two-master round-robin arbiter in front of one external memory port.
// The downstream command is held in a single register slot; a new command can
// be loaded every cycle the slot is not stalled by mem_waitrequest.
// Read data is broadcast to both masters, which filter by their own id.
//
// Ports:
//   clock, reset (sync, active high)
//   m0_* / m1_*  : master side  - waitrequest out; id, address, read, write,
//                  writedata, writedatamask in
//   mem_*        : memory side  - waitrequest, readdata, readdataid in;
//                  id, address, read, write, writedata, writedatamask out
//                  (all registered)
//   m_readdata, m_readdataid : combinational broadcast of the read return
//
// Build option MEM_ARB_STATS_EN: adds 32-bit wrapping counters stat_grant0,
// stat_grant1 (accepted transfers per master) and stat_stall (stalled cycles).
// -----------------------------------------------------------------------------
module mem_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int A_W  = MEM_A_W,
    parameter int D_W  = MEM_D_W,
    parameter int ID_W = MEM_ID_W
) (
    input  logic              clock,
    input  logic              reset,

    output logic              m0_waitrequest,
    input  logic [ID_W-1:0]   m0_id,
    input  logic [A_W-1:0]    m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [D_W-1:0]    m0_writedata,
    input  logic [D_W/8-1:0]  m0_writedatamask,

    output logic              m1_waitrequest,
    input  logic [ID_W-1:0]   m1_id,
    input  logic [A_W-1:0]    m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [D_W-1:0]    m1_writedata,
    input  logic [D_W/8-1:0]  m1_writedatamask,

    input  logic              mem_waitrequest,
    output logic [ID_W-1:0]   mem_id,
    output logic [A_W-1:0]    mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [D_W-1:0]    mem_writedata,
    output logic [D_W/8-1:0]  mem_writedatamask,
    input  logic [D_W-1:0]    mem_readdata,
    input  logic [ID_W-1:0]   mem_readdataid,

    output logic [D_W-1:0]    m_readdata,
    output logic [ID_W-1:0]   m_readdataid
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_stall
`endif
);

    logic [ID_W-1:0]  mem_id_r;
    logic [A_W-1:0]   mem_address_r;
    logic             mem_read_r;
    logic             mem_write_r;
    logic [D_W-1:0]   mem_writedata_r;
    logic [D_W/8-1:0] mem_writedatamask_r;
    logic             last_r;

    logic [1:0]       req_s;
    logic [1:0]       grant_s;
    logic             stall_s;

    logic [ID_W-1:0]  sel_id_s;
    logic [A_W-1:0]   sel_address_s;
    logic             sel_read_s;
    logic             sel_write_s;
    logic [D_W-1:0]   sel_writedata_s;
    logic [D_W/8-1:0] sel_writedatamask_s;

    assign req_s   = {m1_read | m1_write, m0_read | m0_write};
    // The slot only blocks when it holds a command the memory has not taken.
    assign stall_s = (mem_read_r | mem_write_r) & mem_waitrequest;

    rr_grant2 u_rr_grant2 (
        .req   (req_s),
        .last  (last_r),
        .grant (grant_s)
    );

    assign m0_waitrequest = stall_s | ~grant_s[0];
    assign m1_waitrequest = stall_s | ~grant_s[1];

    // Mux the granted master's command toward the slot register
    always_comb begin
        sel_id_s            = m0_id;
        sel_address_s       = m0_address;
        sel_read_s          = cmd_read_eff(m0_read, m0_write);
        sel_write_s         = m0_write;
        sel_writedata_s     = m0_writedata;
        sel_writedatamask_s = m0_writedatamask;
        if (grant_s[1]) begin
            sel_id_s            = m1_id;
            sel_address_s       = m1_address;
            sel_read_s          = cmd_read_eff(m1_read, m1_write);
            sel_write_s         = m1_write;
            sel_writedata_s     = m1_writedata;
            sel_writedatamask_s = m1_writedatamask;
        end else begin
            sel_id_s            = m0_id;
            sel_address_s       = m0_address;
        end
    end

    // Command slot: load on grant, empty when idle, hold while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_id_r            <= ID_W'(ID_NONE);
            mem_address_r       <= '0;
            mem_read_r          <= 1'b0;
            mem_write_r         <= 1'b0;
            mem_writedata_r     <= '0;
            mem_writedatamask_r <= '0;
            last_r              <= 1'b1;
        end else if (!stall_s) begin
            if (grant_s != 2'b00) begin
                mem_id_r            <= sel_id_s;
                mem_address_r       <= sel_address_s;
                mem_read_r          <= sel_read_s;
                mem_write_r         <= sel_write_s;
                mem_writedata_r     <= sel_writedata_s;
                mem_writedatamask_r <= sel_writedatamask_s;
                last_r              <= grant_s[1];
            end else begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
            end
        end else begin
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
        end
    end

    assign mem_id            = mem_id_r;
    assign mem_address       = mem_address_r;
    assign mem_read          = mem_read_r;
    assign mem_write         = mem_write_r;
    assign mem_writedata     = mem_writedata_r;
    assign mem_writedatamask = mem_writedatamask_r;

    // Returns are neither reordered nor queued.
    assign m_readdata   = mem_readdata;
    assign m_readdataid = mem_readdataid;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_grant0_r;
    logic [31:0] stat_grant1_r;
    logic [31:0] stat_stall_r;

    // Wrapping event counters for accepted transfers and stalled cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_grant0_r <= 32'd0;
            stat_grant1_r <= 32'd0;
            stat_stall_r  <= 32'd0;
        end else begin
            if (grant_s[0] && !stall_s) begin
                stat_grant0_r <= stat_grant0_r + 32'd1;
            end else begin
                stat_grant0_r <= stat_grant0_r;
            end
            if (grant_s[1] && !stall_s) begin
                stat_grant1_r <= stat_grant1_r + 32'd1;
            end else begin
                stat_grant1_r <= stat_grant1_r;
            end
            if (stall_s) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_grant0 = stat_grant0_r;
    assign stat_grant1 = stat_grant1_r;
    assign stat_stall  = stat_stall_r;
`endif

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master round-robin arbiter sharing one external memory port: mem_waitrequest/read/write/address/writedata/writedatamask/id/readdata/readdataid.
- Sits between two requesters (e.g. a CPU data port and a memory test master) and the SDRAM/SRAM controller.
- The downstream command is registered, giving one command slot.
- Read data is broadcast to both masters; each master filters returns by its own mem_id.

Parameters:
A_W, 30, word address width
D_W, 32, data width
ID_W, 2, transaction id width; id 0 reserved for "no read data"

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_waitrequest  out  1  stall to master 0
m0_id  in  ID_W  master 0 transaction id (nonzero, distinct from m1_id)
m0_address  in  A_W  master 0 word address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  D_W  master 0 write data
m0_writedatamask  in  D_W/8  master 0 byte enables
m1_*  (same six inputs and one output as m0_*)  master 1
mem_waitrequest  in  1  downstream stall
mem_id  out  ID_W  registered id
mem_address  out  A_W  registered address
mem_read  out  1  registered read strobe
mem_write  out  1  registered write strobe
mem_writedata  out  D_W  registered write data
mem_writedatamask  out  D_W/8  registered byte enables
mem_readdata  in  D_W  downstream read data
mem_readdataid  in  ID_W  downstream read-data id; 0 = no data
m_readdata  out  D_W  broadcast of mem_readdata, combinational
m_readdataid  out  ID_W  broadcast of mem_readdataid, combinational

Behaviour:
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_writedatamask=0, mem_id=0, last=1 (so m0 wins the first tie).
- Request: master i requests when mi_read|mi_write. A transfer is accepted at the rising edge where the request is high and mi_waitrequest=0. The master holds its command stable until then.
- Slot state: slot_busy = mem_read|mem_write.
- stall = slot_busy & mem_waitrequest, where stall is combinational on mem_waitrequest.
- Grant (combinational):
  - only one master requesting: that master is granted;
  - both requesting: grant the master != last;
  - none requesting: no grant.
- mi_waitrequest = stall | ~grant_i. A non-requesting master sees 1.
- On an edge with ~stall:
  - If a grant exists, load the granted master's command into the mem_* registers and set last = granted index.
  - If no grant exists, clear mem_read and mem_write; other mem_* fields hold their values.
- On an edge with stall: all mem_* registers hold.
- Latency: master accept to mem_* valid is 1 cycle. Back-to-back throughput is 1 command per cycle when mem_waitrequest=0.
- Fairness: under continuous dual requests, grants strictly alternate m0, m1, m0, …
- read and write asserted together by one master is illegal. The write wins and mem_read is loaded as 0.
- Read returns are not reordered or queued. m_readdata/m_readdataid pass through unchanged in the same cycle.
- Reset mid-operation: an in-flight mem command is dropped and mem_read/mem_write are 0 the next cycle. Read data still in flight downstream is broadcast; masters discard it by their own reset.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs stat_grant0 (32), stat_grant1 (32) and stat_stall (32).
  - stat_grantN increments on each accepted transfer of master N.
  - stat_stall increments on each cycle where stall=1.
  - All three counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent. The arbitration behaviour is identical either way.

Decomposition:
- Shared package mem_bus_pkg holds:
  - A_W/D_W/ID_W defaults;
  - localparam ID_NONE=0;
  - a command struct {id, address, read, write, writedata, writedatamask} reused by masters and controllers.
- One natural sub-module: rr_grant2, the combinational 2-way round-robin pick from (req[1:0], last), outputting grant[1:0]. Everything else stays in mem_arbiter2.

Test Plan:
- m0 write addr 0x10 data 0x0000_0A55 with mem_waitrequest=0 -> m0_waitrequest=0 that cycle; next cycle mem_write=1, mem_address=0x10, mem_id=m0_id, mem_writedata=0x0000_0A55.
- m0 and m1 both read continuously (ids 1, 2) with mem_waitrequest=0 -> mem_id sequence 1,2,1,2…; after reset, m0 is granted first.
- Slot busy and mem_waitrequest held 1 for 3 cycles -> mem_* stable for 3 cycles; both mi_waitrequest=1; stat_stall +3 when MEM_ARB_STATS_EN is defined.
- m1 asserts read=1 and write=1 together, addr 0x7 -> mem_write=1, mem_read=0 at addr 0x7.
- mem_readdataid=2, mem_readdata=0xDEAD_BEEF -> same cycle m_readdataid=2, m_readdata=0xDEAD_BEEF.
- Reset asserted while mem_read=1 under mem_waitrequest=1 -> next cycle mem_read=0, mem_write=0, mem_id=0, last=1; then one m1-only request is granted immediately.
